pc_fetch_unit: RTL and testbench

//  Instruction-fetch front end: owns the PC register, issues instruction-memory reads and hands {PC, instr} to decode.

---
 rtl/riscv_fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/pc_fetch_unit.sv | 116 +++++++++++
 tb/tb_pc_fetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package riscv_fetch_pkg;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  // One fetched instruction as handed toward decode; pc is narrowed by the user.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a single-cycle clear.
// Depth need not be a power of two; pointers wrap explicitly.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  fetch_entry_t       i_data,
  input  logic               i_pop,
  input  logic               i_clear,
  output fetch_entry_t       o_head,
  output logic               o_empty,
  output logic               o_full,
  output logic [CNT_W-1:0]   o_count
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign o_empty   = (r_count == CNT_W'(0));
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign w_push_ok = i_push && (!o_full || i_pop);
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = o_empty ? fetch_entry_t'(64'h0) : r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; clear discards everything in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= fetch_entry_t'(64'h0);
      end
    end else if (i_clear) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= CNT_W'(0);
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order imem reads,
// buffers responses and presents {PC, instr} to decode. A branch redirect
// flushes buffered work and discards responses still in flight.
module pc_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int RESET_PC  = 0,
  parameter int MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Stall,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            If_valid,
  output logic [PC_W-1:0] If_PC,
  output logic [31:0]     If_Instr,
  output logic            Flush
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_rsp_pc;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] r_drop_cnt;

  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_entry;
  logic             w_credit;
  logic             w_accept;
  logic             w_rsp;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_inflight_next;
  logic [PC_W-1:0]  w_target;
  logic             w_unused;

  // Credit covers both requests in flight and responses parked in the FIFO,
  // so a response can never find the FIFO full.
  assign w_credit = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < SUM_W'(MAX_OUTST);

  assign imem_req_valid = reset && !PcSel && w_credit;
  assign imem_addr      = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  // A response with nothing in flight is a protocol error and is ignored.
  assign w_rsp  = imem_rsp_valid && (r_inflight != CNT_W'(0));
  assign w_push = w_rsp && !PcSel && (r_drop_cnt == CNT_W'(0));
  assign w_inflight_next = r_inflight + CNT_W'(w_accept) - CNT_W'(w_rsp);

  assign w_target     = {BrPC[PC_W-1:2], 2'b00};
  assign w_push_entry = '{pc: 32'(r_rsp_pc), instr: imem_rsp_data};

  assign If_valid = reset && !w_fifo_empty && !PcSel;
  assign If_PC    = w_head.pc[PC_W-1:0];
  assign If_Instr = w_head.instr;
  assign Flush    = reset && PcSel;
  assign w_pop    = If_valid && !Stall;

  assign w_unused = &{1'b0, BrPC[31:PC_W], BrPC[1:0], w_fifo_full, w_head.pc[31:PC_W]};

  fetch_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_clear (PcSel),
    .o_head  (w_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  // PC, response-PC and outstanding/drop bookkeeping; redirect overrides all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= PC_W'(RESET_PC);
      r_rsp_pc   <= PC_W'(RESET_PC);
      r_inflight <= CNT_W'(0);
      r_drop_cnt <= CNT_W'(0);
    end else begin
      r_inflight <= w_inflight_next;
      if (PcSel) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_pc       <= w_target;
        r_rsp_pc   <= w_target;
        r_drop_cnt <= w_inflight_next;
      end else begin
        if (w_accept) begin
          r_pc <= r_pc + PC_W'(INSTR_BYTES);
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + PC_W'(INSTR_BYTES);
        end
        if (w_rsp && (r_drop_cnt != CNT_W'(0))) begin
          r_drop_cnt <= r_drop_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a behavioural imem answers accepted
// requests after a programmable latency; expected request addresses and
// expected decode-side outputs are queued by the stimulus and compared by
// the request hook and an independent output monitor.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PcSel;
  logic [31:0] BrPC;
  logic        Stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [8:0]  imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        If_valid;
  logic [8:0]  If_PC;
  logic [31:0] If_Instr;
  logic        Flush;

  typedef struct { logic [8:0] addr; int due; } pend_t;
  typedef struct { logic [8:0] pc; logic [31:0] instr; } if_t;

  pend_t      pend_q[$];
  if_t        exp_if_q[$];
  logic [8:0] exp_addr_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int budget = 0;
  int lat    = 1;

  logic        rst_v   = 1'b0;
  logic        pcsel_v = 1'b0;
  logic        stall_v = 1'b0;
  logic [31:0] brpc_v  = 32'h0;

  pc_fetch_unit #(.PC_W(9), .RESET_PC(0), .MAX_OUTST(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .PcSel          (PcSel),
    .BrPC           (BrPC),
    .Stall          (Stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .If_valid       (If_valid),
    .If_PC          (If_PC),
    .If_Instr       (If_Instr),
    .Flush          (Flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Instruction memory contents: word at byte address a holds 0xA0 + a/4.
  function automatic logic [31:0] mem_data(input logic [8:0] a);
    return 32'h0000_00A0 + ({23'h0, a} >> 2);
  endfunction

  task automatic exp_a(input logic [8:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic exp_i(input logic [8:0] pc, input logic [31:0] instr);
    if_t e;
    e.pc = pc;
    e.instr = instr;
    exp_if_q.push_back(e);
  endtask

  // One clock: drive inputs on the falling edge, then observe request handshake.
  task automatic step();
    pend_t p;
    @(negedge clk);
    cyc++;
    reset          = rst_v;
    PcSel          = pcsel_v;
    BrPC           = brpc_v;
    Stall          = stall_v;
    imem_req_ready = (budget > 0);
    if (rst_v && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req actual=%h required=none", imem_addr);
      end else begin
        chk("req_addr", {23'h0, imem_addr}, {23'h0, exp_addr_q.pop_front()});
      end
      p.addr = imem_addr;
      p.due  = cyc + lat;
      pend_q.push_back(p);
      budget--;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    stall_v = 1'b0;
    pcsel_v = 1'b0;
    while ((exp_if_q.size() != 0 || pend_q.size() != 0 || budget != 0) && n < 80) begin
      step();
      n++;
    end
    chk({name, "_in_time"}, {31'h0, n < 80}, 32'h1);
    chk({name, "_if_left"}, exp_if_q.size(), 32'h0);
    chk({name, "_addr_left"}, exp_addr_q.size(), 32'h0);
  endtask

  // Output monitor: every instruction consumed by decode must match the queue head.
  always begin : monitor
    if_t e;
    @(negedge clk);
    #2;
    if (reset && If_valid && !Stall) begin
      if (exp_if_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_if actual=%h/%h required=none", If_PC, If_Instr);
      end else begin
        e = exp_if_q.pop_front();
        chk("if_pc", {23'h0, If_PC}, {23'h0, e.pc});
        chk("if_instr", If_Instr, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; PcSel = 1'b0; BrPC = 32'h0; Stall = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

    // Reset state
    rst_v = 1'b0;
    step();
    step();
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_if_valid", {31'h0, If_valid}, 32'h0);
    chk("rst_flush", {31'h0, Flush}, 32'h0);
    chk("rst_if_pc", {23'h0, If_PC}, 32'h0);
    chk("rst_if_instr", If_Instr, 32'h0);

    // Reset asserted with two requests in flight
    rst_v = 1'b1; lat = 3; budget = 2;
    exp_a(9'h000); exp_a(9'h004);
    step();
    step();
    rst_v = 1'b0;
    step();
    chk("midrst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("midrst_if_valid", {31'h0, If_valid}, 32'h0);
    pend_q.delete();
    budget = 0;
    step();
    chk("midrst_addr", {23'h0, imem_addr}, 32'h0);

    // Straight-line fetch after reset, single-cycle imem
    rst_v = 1'b1; lat = 1; budget = 4;
    exp_a(9'h000); exp_a(9'h004); exp_a(9'h008); exp_a(9'h00C);
    exp_i(9'h000, 32'hA0); exp_i(9'h004, 32'hA1);
    exp_i(9'h008, 32'hA2); exp_i(9'h00C, 32'hA3);
    drain("seq");

    // Decode stall fills the buffer and holds the head
    stall_v = 1'b1; budget = 3;
    exp_a(9'h010); exp_a(9'h014); exp_a(9'h018);
    exp_i(9'h010, 32'hA4); exp_i(9'h014, 32'hA5); exp_i(9'h018, 32'hA6);
    step();
    step();
    step();
    chk("stall_head_pc_early", {23'h0, If_PC}, 32'h010);
    step();
    chk("stall_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("stall_if_valid", {31'h0, If_valid}, 32'h1);
    chk("stall_head_pc", {23'h0, If_PC}, 32'h010);
    chk("stall_head_instr", If_Instr, 32'hA4);
    drain("stall");

    // Redirect with two stale requests in flight
    lat = 3; budget = 4;
    exp_a(9'h01C); exp_a(9'h020); exp_a(9'h040); exp_a(9'h044);
    exp_i(9'h040, 32'hB0); exp_i(9'h044, 32'hB1);
    step();
    step();
    pcsel_v = 1'b1; brpc_v = 32'h0000_0040;
    step();
    chk("redir_flush", {31'h0, Flush}, 32'h1);
    chk("redir_if_valid", {31'h0, If_valid}, 32'h0);
    chk("redir_req_valid", {31'h0, imem_req_valid}, 32'h0);
    pcsel_v = 1'b0;
    step();
    chk("redir_flush_drop", {31'h0, Flush}, 32'h0);
    drain("redirect");

    // PC wraps past the top of the address space
    lat = 1;
    pcsel_v = 1'b1; brpc_v = 32'h0000_01FC;
    step();
    chk("wrap_flush", {31'h0, Flush}, 32'h1);
    pcsel_v = 1'b0; budget = 2;
    exp_a(9'h1FC); exp_a(9'h000);
    exp_i(9'h1FC, 32'h11F); exp_i(9'h000, 32'hA0);
    drain("wrap");

    // Redirect, stall and response in the same cycle; unaligned target
    stall_v = 1'b1; budget = 2;
    exp_a(9'h004); exp_a(9'h008); exp_a(9'h100);
    exp_i(9'h100, 32'hE0);
    step();
    step();
    pcsel_v = 1'b1; brpc_v = 32'h0000_0103;
    step();
    chk("t6_if_valid", {31'h0, If_valid}, 32'h0);
    chk("t6_flush", {31'h0, Flush}, 32'h1);
    chk("t6_req_valid", {31'h0, imem_req_valid}, 32'h0);
    pcsel_v = 1'b0; stall_v = 1'b0; budget = 1;
    step();
    chk("t6_cleared", {31'h0, If_valid}, 32'h0);
    drain("redir_stall");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
